// File: rtl/sumador_pipeline_param.sv
// sumador_pipeline_param: add/sub pipelined over SEG-bit carry segments,
// one segment per register stage, with a globally stalled valid/ready flow.
module sumador_pipeline_param #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [IDX_W-1:0] idx,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             ovf_out,
    output logic [IDX_W-1:0] idx_out
);
    localparam int STAGES = WIDTH / SEG;

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    logic advance;

    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t       src;
        stage_t       nxt;
        logic [SEG:0] t;

        if (k == 0) begin : g_head
            // B is inverted up front; the subtract's +1 is the first carry-in.
            always_comb begin
                src       = '0;
                src.valid = in_valid;
                src.sub   = sub;
                src.idx   = idx;
                src.a     = dataA;
                src.b     = sub ? ~dataB : dataB;
                src.c     = sub;
            end
        end else begin : g_link
            assign src = g_stage[k-1].g_reg.q;
        end

        assign t = {1'b0, src.a[k*SEG +: SEG]}
                 + {1'b0, src.b[k*SEG +: SEG]}
                 + {{SEG{1'b0}}, src.c};

        always_comb begin
            nxt                  = src;
            nxt.s[k*SEG +: SEG]  = t[SEG-1:0];
            nxt.c                = t[SEG];
        end

        if (k < STAGES - 1) begin : g_reg
            stage_t q;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    q <= '0;
                end else if (advance) begin
                    q <= nxt;
                end
            end
        end else begin : g_out
            logic unused_fields;

            assign unused_fields = ^nxt;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    out_valid <= 1'b0;
                    sum_out   <= '0;
                    carry_out <= 1'b0;
                    ovf_out   <= 1'b0;
                    idx_out   <= '0;
                end else if (advance) begin
                    out_valid <= nxt.valid;
                    sum_out   <= nxt.s;
                    carry_out <= nxt.c;
                    ovf_out   <= (nxt.a[WIDTH-1] == nxt.b[WIDTH-1])
                              && (nxt.s[WIDTH-1] != nxt.a[WIDTH-1]);
                    idx_out   <= nxt.idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_sumador_pipeline_param.sv
// Scoreboard bench for sumador_pipeline_param: directed vectors on an 8/4
// instance plus random sweeps on 8/4, 16/4 and 8/8 instances.
module tb_sumador_pipeline_param;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        ovf;
        logic [3:0]  idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dataA;
    logic [7:0] dataB;
    logic [3:0] idx;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_out;
    logic       carry_out;
    logic       ovf_out;
    logic [3:0] idx_out;

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    logic sweep_go = 1'b0;
    int   extra_done = 0;

    always #5 clk = ~clk;

    sumador_pipeline_param #(.WIDTH(8), .SEG(4), .IDX_W(4)) u_dut (
        .clk(clk),
        .reset_L(reset_L),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dataA(dataA),
        .dataB(dataB),
        .idx(idx),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out(sum_out),
        .carry_out(carry_out),
        .ovf_out(ovf_out),
        .idx_out(idx_out)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whole-width reference, independent of the segmented datapath.
    function automatic exp_t model(input int w, input logic [15:0] a,
                                   input logic [15:0] b, input logic s,
                                   input logic [3:0] id);
        logic [16:0] full;
        logic [15:0] mask;
        logic [15:0] am;
        logic [15:0] bp;
        exp_t        e;
        mask  = 16'((17'd1 << w) - 17'd1);
        am    = a & mask;
        bp    = s ? (~b & mask) : (b & mask);
        full  = {1'b0, am} + {1'b0, bp} + {16'd0, s};
        e.sum = full[15:0] & mask;
        e.c   = full[w];
        e.ovf = (am[w-1] == bp[w-1]) && (e.sum[w-1] != am[w-1]);
        e.idx = id;
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] s, input logic c,
                                input logic o, input logic [3:0] i);
        exp_t e;
        e.sum = {8'd0, s};
        e.c   = c;
        e.ovf = o;
        e.idx = i;
        return e;
    endfunction

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic [3:0] ti,
                        input exp_t e);
        int n;
        n        = 0;
        dataA    = ta;
        dataB    = tb_;
        sub      = ts;
        idx      = ti;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout idx=%0h actual=stalled required=accept", ti);
        end else begin
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (q0.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q0.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 8/4 instance: scoreboard pops plus stall checks.
    initial begin : mon0
        logic       prev_stall;
        logic [7:0] prev_sum;
        logic [3:0] prev_idx;
        exp_t       e;
        prev_stall = 1'b0;
        prev_sum   = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (reset_L !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && out_valid) begin
                    check("hold_sum", 32'(sum_out), 32'(prev_sum));
                    check("hold_idx", 32'(idx_out), 32'(prev_idx));
                end
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    prev_stall = 1'b1;
                    prev_sum   = sum_out;
                    prev_idx   = idx_out;
                end else begin
                    prev_stall = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (q0.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out idx=%0h sum=%0h required=none",
                                 idx_out, sum_out);
                    end else begin
                        e = q0.pop_front();
                        check("sum", 32'(sum_out), 32'(e.sum[7:0]));
                        check("carry", 32'(carry_out), 32'(e.c));
                        check("ovf", 32'(ovf_out), 32'(e.ovf));
                        check("idx", 32'(idx_out), 32'(e.idx));
                    end
                end
            end
        end
    end

    // Extra configurations for the random sweep: 16/4 and 8/8.
    for (genvar g = 0; g < 2; g++) begin : g_extra
        localparam int W = (g == 0) ? 16 : 8;
        localparam int S = (g == 0) ? 4 : 8;

        logic         iv;
        logic         ir;
        logic         sb;
        logic         ov;
        logic         ordy;
        logic         co;
        logic         vo;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] so;
        logic [3:0]   id;
        logic [3:0]   ido;
        exp_t         q[$];
        logic         done;

        sumador_pipeline_param #(.WIDTH(W), .SEG(S), .IDX_W(4)) u_x (
            .clk(clk),
            .reset_L(reset_L),
            .in_valid(iv),
            .in_ready(ir),
            .dataA(a),
            .dataB(b),
            .idx(id),
            .sub(sb),
            .out_valid(ov),
            .out_ready(ordy),
            .sum_out(so),
            .carry_out(co),
            .ovf_out(vo),
            .idx_out(ido)
        );

        task automatic xsend(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                             input logic ts, input logic [3:0] ti);
            int n;
            n  = 0;
            a  = ta;
            b  = tb_;
            sb = ts;
            id = ti;
            iv = 1'b1;
            @(negedge clk);
            while (!ir && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!ir) begin
                checks++;
                failures++;
                $display("FAIL x%0d_send_timeout actual=stalled required=accept", g);
            end else begin
                q.push_back(model(W, 16'(ta), 16'(tb_), ts, ti));
            end
            @(posedge clk);
            #1;
            iv = 1'b0;
        endtask

        initial begin : stim
            int n;
            iv   = 1'b0;
            ordy = 1'b1;
            a    = '0;
            b    = '0;
            sb   = 1'b0;
            id   = '0;
            done = 1'b0;
            n    = 0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            fork
                begin
                    for (int i = 0; i < 20; i++) begin
                        xsend(W'($urandom), W'($urandom), 1'($urandom), 4'(i));
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        ordy = 1'($urandom_range(0, 1));
                    end
                    ordy = 1'b1;
                end
            join
            while (q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("x%0d_drain", g), 32'(q.size()), 32'd0);
            extra_done++;
        end

        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                if (reset_L === 1'b1 && ov && ordy) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL x%0d_unexpected_out idx=%0h required=none", g, ido);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("x%0d_sum", g), 32'(so), 32'(e.sum[W-1:0]));
                        check($sformatf("x%0d_carry", g), 32'(co), 32'(e.c));
                        check($sformatf("x%0d_ovf", g), 32'(vo), 32'(e.ovf));
                        check($sformatf("x%0d_idx", g), 32'(ido), 32'(e.idx));
                    end
                end
            end
        end
    end

    initial begin : main
        logic done0;
        int   n;
        reset_L   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dataA     = '0;
        dataB     = '0;
        idx       = '0;
        sub       = 1'b0;
        done0     = 1'b0;
        n         = 0;

        repeat (3) begin
            @(posedge clk);
            #1;
            dataA    = 8'($urandom);
            dataB    = 8'($urandom);
            idx      = 4'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum_out), 32'd0);
            check("rst_carry", 32'(carry_out), 32'd0);
            check("rst_ovf", 32'(ovf_out), 32'd0);
            check("rst_idx", 32'(idx_out), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_L  = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(8'h0F, 8'h01, 1'b0, 4'd3, mk(8'h10, 1'b0, 1'b0, 4'd3));
        check("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        send(8'hF8, 8'h0A, 1'b0, 4'd5, mk(8'h02, 1'b1, 1'b0, 4'd5));
        send(8'h05, 8'h07, 1'b1, 4'd6, mk(8'hFE, 1'b0, 1'b0, 4'd6));
        send(8'h80, 8'h01, 1'b1, 4'd7, mk(8'h7F, 1'b1, 1'b1, 4'd7));
        send(8'h7F, 8'h01, 1'b0, 4'd8, mk(8'h80, 1'b0, 1'b1, 4'd8));
        send(8'hFF, 8'h01, 1'b0, 4'd9, mk(8'h00, 1'b1, 1'b0, 4'd9));
        send(8'h00, 8'h00, 1'b1, 4'd10, mk(8'h00, 1'b1, 1'b0, 4'd10));
        drain0();

        fork
            begin
                send(8'h10, 8'h01, 1'b0, 4'd1, mk(8'h11, 1'b0, 1'b0, 4'd1));
                send(8'h20, 8'h01, 1'b0, 4'd2, mk(8'h21, 1'b0, 1'b0, 4'd2));
                send(8'h30, 8'h01, 1'b0, 4'd3, mk(8'h31, 1'b0, 1'b0, 4'd3));
                send(8'h40, 8'h01, 1'b0, 4'd4, mk(8'h41, 1'b0, 1'b0, 4'd4));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain0();

        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 4'd11, mk(8'h33, 1'b0, 1'b0, 4'd11));
        send(8'h01, 8'h02, 1'b0, 4'd12, mk(8'h03, 1'b0, 1'b0, 4'd12));
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_L = 1'b0;
        q0.delete();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_idx", 32'(idx_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_L   = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'h33, 8'h44, 1'b0, 4'd13, mk(8'h77, 1'b0, 1'b0, 4'd13));
        drain0();

        sweep_go = 1'b1;
        fork
            begin
                logic [7:0] ra;
                logic [7:0] rb;
                logic       rs;
                for (int i = 0; i < 20; i++) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rs = 1'($urandom);
                    send(ra, rb, rs, 4'(i), model(8, {8'd0, ra}, {8'd0, rb}, rs, 4'(i)));
                end
                done0 = 1'b1;
            end
            begin
                while (!done0) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain0();

        while (extra_done < 2 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("extras_done", 32'(extra_done), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sumador_pipeline_param.md
Name: sumador_pipeline_param

Overview:
- Parametrised successor to the fixed 4-bit two-stage pipelined adder.
- Generalised in operand width and pipeline depth: the carry chain is split into SEG-bit segments, one segment per register stage, with input skew and output deskew.
- Adds a per-transaction add/subtract mode, carry-out and signed-overflow flags, an idx tag carried alongside the result, and a valid/ready handshake with backpressure.
- Sits between the stimulus/source side and the result consumer; it replaces the fixed adder in the same benches.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be a multiple of SEG.
- SEG, 4: segment width per stage. STAGES = WIDTH/SEG (latency in cycles, ≥1).
- IDX_W, 4: width of the idx tag carried through unchanged.

Ports:
- clk  input  1  rising-edge clock
- reset_L  input  1  asynchronous active-low reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block accepts input this cycle
- dataA  input  WIDTH  operand A
- dataB  input  WIDTH  operand B
- idx  input  IDX_W  tag
- sub  input  1  0 = A+B, 1 = A−B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum_out  output  WIDTH  result modulo 2^WIDTH
- carry_out  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf_out  output  1  two's-complement signed overflow
- idx_out  output  IDX_W  tag of this result

Behaviour:
- Reset: clk and reset_L are the only clock and reset. Reset is asynchronous and active-low. While reset_L=0, every register (all stage valids, data, carries, tags) and every output is 0; in_ready is 1 after release.
- Handshake and stall:
  - in_ready = !out_valid || out_ready. A transfer happens when in_valid && in_ready.
  - Global stall: the pipeline advances only when in_ready=1, and all stages shift together.
  - Bubbles (in_valid=0 when in_ready=1) propagate as invalid stages.
  - While stalled (out_valid=1, out_ready=0), all outputs hold stable and nothing is lost or duplicated.
- Latency: an accepted transaction with no stall appears with out_valid=1 exactly STAGES cycles after the accepting edge. Results leave in acceptance order.
- Subtract: the effective operand is B' = sub ? ~dataB : dataB, and the stage-0 carry-in is sub.
- Stage k (0..STAGES−1):
  - computes {c_k, s_k} = A[k] + B'[k] + c_(k−1) on SEG bits;
  - registers s_k plus the lower result segments already computed;
  - carries upper A/B' segments, sub, idx and valid forward unchanged.
- Final stage outputs:
  - carry_out = c_(STAGES−1);
  - ovf_out = (A_msb == B'_msb) && (sum_msb != A_msb).
- STAGES=1: a single registered full-width adder with latency 1.
- Width: all arithmetic is modulo 2^WIDTH. There is no saturation.
- Reset mid-operation: asserting reset_L=0 at any time discards all in-flight transactions immediately, with no clock needed. The first result after release comes from the first transaction accepted after release.
- Simultaneous output and input: when out_valid && out_ready && in_valid, the output pops and a new input is accepted on the same edge, with no bubble inserted.

Test Plan:
- Reset (defaults: WIDTH=8, SEG=4). Hold reset_L=0 for 3 cycles with random inputs → out_valid=0, sum_out=0x00, carry_out=0, ovf_out=0, idx_out=0, in_ready=1.
- Add with carry across segments.
  - A=0x0F, B=0x01, idx=3, sub=0 → 2 cycles later: sum_out=0x10, carry_out=0, ovf_out=0, idx_out=3.
  - A=0xF8, B=0x0A → sum_out=0x02, carry_out=1, ovf_out=0.
- Subtract.
  - A=0x05, B=0x07, sub=1 → sum_out=0xFE, carry_out=0 (borrow), ovf_out=0.
  - A=0x80, B=0x01, sub=1 → sum_out=0x7F, carry_out=1, ovf_out=1.
- Backpressure. Stream 4 transactions (idx 1..4) with out_ready=0 from cycle 3 for 4 cycles →
  - in_ready=0 while out_valid=1;
  - idx_out and sum_out held stable;
  - after out_ready=1: idx 1,2,3,4 emerged once each, in order.
- Async reset mid-flight. Pull reset_L low between clock edges with 2 valid transactions in flight → out_valid=0 immediately; after release no stale result appears.
- Random sweep. 20 back-to-back random transactions per configuration {WIDTH=8,SEG=4}, {WIDTH=16,SEG=4}, {WIDTH=8,SEG=8}, with random out_ready → every result matches the behavioural reference model (sum, carry, ovf, idx) and no discrepancy is flagged.
